// File: rtl/stack_ctrl_if.sv
// Request, status and RAM-side signals of one stack controller.
// The slave modport is the controller; the master modport is the CPU plus the stack RAM.
interface stack_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 8
);
    logic                  op_valid;
    logic                  op_ready;
    logic [1:0]            op;
    logic [WIDTH-1:0]      push_data;
    logic [WIDTH-1:0]      tos;
    logic [DEPTH_BITS:0]   depth;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;
    logic [DEPTH_BITS-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic                  mem_wen;
    logic [WIDTH-1:0]      mem_dout;

    modport master (
        output op_valid, op, push_data, err_clr, mem_dout,
        input  op_ready, tos, depth, empty, full, overflow, underflow,
               mem_addr, mem_din, mem_wen
    );

    modport slave (
        input  op_valid, op, push_data, err_clr, mem_dout,
        output op_ready, tos, depth, empty, full, overflow, underflow,
               mem_addr, mem_din, mem_wen
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: top-of-stack cached in a register, remaining entries
// spilled to / refilled from an external synchronous single-port RAM.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for an op; RAM signals decoded from the incoming op
// REFILL | RAM read issued by a POP is returning; load it into tos
module stack_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 8
) (
    input logic        clk,
    input logic        reset,
    stack_ctrl_if.slave bus
);
    typedef enum logic {IDLE, REFILL} state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    localparam logic [DEPTH_BITS:0] CAP = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] D_ZERO = '0;
    localparam logic [DEPTH_BITS:0] D_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        tos_q, tos_d;
    logic [DEPTH_BITS:0]     depth_q, depth_d;
    logic [DEPTH_BITS-1:0]   raddr_q, raddr_d;
    logic                    ovf_q, ovf_d, udf_q, udf_d;
    logic                    ovf_set, udf_set;
    logic                    ready;
    logic                    wen;
    logic [DEPTH_BITS-1:0]   addr;
    logic [WIDTH-1:0]        din;
    logic [DEPTH_BITS-1:0]   depth_lo;

    // Low bits of depth; modulo arithmetic on these gives the RAM slot even at depth==CAP.
    assign depth_lo = depth_q[DEPTH_BITS-1:0];

    // Next-state, RAM decode and handshake.
    always_comb begin
        state_d = state_q;
        tos_d   = tos_q;
        depth_d = depth_q;
        raddr_d = raddr_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        ready   = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        din     = '0;
        case (state_q)
            IDLE: begin
                ready = reset;
                if (reset && bus.op_valid) begin
                    case (bus.op)
                        OP_PUSH: begin
                            if (depth_q == D_ZERO) begin
                                tos_d   = bus.push_data;
                                depth_d = D_ONE;
                            end else if (depth_q == CAP) begin
                                ovf_set = 1'b1;
                            end else begin
                                wen     = 1'b1;
                                addr    = depth_lo - DEPTH_BITS'(1);
                                din     = tos_q;
                                tos_d   = bus.push_data;
                                depth_d = depth_q + D_ONE;
                            end
                        end
                        OP_POP: begin
                            if (depth_q == D_ZERO) begin
                                udf_set = 1'b1;
                            end else if (depth_q == D_ONE) begin
                                tos_d   = '0;
                                depth_d = D_ZERO;
                            end else begin
                                addr    = depth_lo - DEPTH_BITS'(2);
                                raddr_d = depth_lo - DEPTH_BITS'(2);
                                depth_d = depth_q - D_ONE;
                                state_d = REFILL;
                            end
                        end
                        OP_REPLACE: begin
                            if (depth_q == D_ZERO) udf_set = 1'b1;
                            else                  tos_d   = bus.push_data;
                        end
                        OP_NOP: ;
                        default: ;
                    endcase
                end
            end
            REFILL: begin
                addr    = raddr_q;
                tos_d   = bus.mem_dout;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new error event in the same cycle as err_clr keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
        udf_d = udf_set | (udf_q & ~bus.err_clr);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tos_q   <= '0;
            depth_q <= '0;
            raddr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            raddr_q <= raddr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.op_ready  = ready;
    assign bus.mem_wen   = wen;
    assign bus.mem_addr  = addr;
    assign bus.mem_din   = din;
    assign bus.tos       = tos_q;
    assign bus.depth     = depth_q;
    assign bus.empty     = (depth_q == D_ZERO);
    assign bus.full      = (depth_q == CAP);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based stack model.
module tb_stack_ctrl;
    localparam int W   = 16;
    localparam int DB  = 4;
    localparam int CAP = 1 << DB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   wen_cnt = 0;
    int   pop_addrs[$];

    stack_ctrl_if #(.WIDTH(W), .DEPTH_BITS(DB)) bus();
    stack_ctrl #(.WIDTH(W), .DEPTH_BITS(DB)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Stack RAM: synchronous single port, read data one cycle after address.
    logic [W-1:0] ram [0:CAP-1];
    initial for (int i = 0; i < CAP; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue holds the stack; busy marks the cycle a refill is in flight.
    logic [W-1:0] mq[$];
    bit           m_ovf, m_udf, m_busy;
    logic [W-1:0] m_shown;

    always @(posedge clk or negedge reset) begin
        bit os, us;
        if (!reset) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_busy = 0; m_shown = '0;
        end else begin
            os = 0; us = 0;
            if (m_busy) m_busy = 0;
            else if (bus.op_valid) begin
                case (bus.op)
                    2'b01: if (mq.size() == CAP) os = 1; else mq.push_back(bus.push_data);
                    2'b10: if (mq.size() == 0) us = 1;
                           else begin m_shown = mq.pop_back(); if (mq.size() > 0) m_busy = 1; end
                    2'b11: if (mq.size() == 0) us = 1; else mq[mq.size()-1] = bus.push_data;
                    default: ;
                endcase
            end
            m_ovf = os | (m_ovf & !bus.err_clr);
            m_udf = us | (m_udf & !bus.err_clr);
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        int sz;
        logic [W-1:0] etos;
        bit ewen, epop;
        if (bus.mem_wen) wen_cnt++;
        if (!reset) begin
            chk("rst_ready", bus.op_ready, 0);
            chk("rst_wen", bus.mem_wen, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_din", bus.mem_din, 0);
            chk("rst_depth", bus.depth, 0);
            chk("rst_tos", bus.tos, 0);
        end else begin
            sz   = mq.size();
            etos = m_busy ? m_shown : (sz > 0 ? mq[sz-1] : '0);
            ewen = !m_busy && bus.op_valid && bus.op == 2'b01 && sz > 0 && sz < CAP;
            epop = !m_busy && bus.op_valid && bus.op == 2'b10 && sz >= 2;
            if (epop) pop_addrs.push_back(int'(bus.mem_addr));
            chk("ready", bus.op_ready, !m_busy);
            chk("tos", bus.tos, etos);
            chk("depth", bus.depth, sz);
            chk("empty", bus.empty, sz == 0);
            chk("full", bus.full, sz == CAP);
            chk("overflow", bus.overflow, m_ovf);
            chk("underflow", bus.underflow, m_udf);
            chk("mem_wen", bus.mem_wen, ewen);
            if (ewen) begin
                chk("push_addr", bus.mem_addr, sz - 1);
                chk("push_din", bus.mem_din, mq[sz-1]);
            end
            if (epop) chk("pop_addr", bus.mem_addr, sz - 2);
            if (m_busy) chk("refill_addr", bus.mem_addr, sz - 1);
            if (!m_busy && (!bus.op_valid || bus.op == 2'b00)) chk("idle_addr", bus.mem_addr, 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present an op and hold it until accepted; returns tos seen at acceptance.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] d, output logic [W-1:0] t);
        bit acc = 0;
        int n = 0;
        bus.op_valid = 1'b1; bus.op = o; bus.push_data = d;
        t = '0;
        while (!acc && n < 8) begin
            @(negedge clk);
            acc = bus.op_ready;
            t = bus.tos;
            step();
            n++;
        end
        if (!acc) begin
            n_checks++; n_err++;
            $display("FAIL issue_timeout: op %0d not accepted, ready=%0b required 1", o, bus.op_ready);
        end
        bus.op_valid = 1'b0; bus.op = 2'b00;
    endtask

    initial begin
        logic [W-1:0] t;
        int w0;
        bit r;
        bus.op_valid = 0; bus.op = 0; bus.push_data = 0; bus.err_clr = 0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Three pushes.
        w0 = wen_cnt;
        issue(2'b01, 16'h1111, t);
        issue(2'b01, 16'h2222, t);
        issue(2'b01, 16'h3333, t);
        chk("t1_tos", bus.tos, 16'h3333);
        chk("t1_depth", bus.depth, 3);
        chk("t1_ram0", ram[0], 16'h1111);
        chk("t1_ram1", ram[1], 16'h2222);
        chk("t1_wen_pulses", wen_cnt - w0, 2);

        // Pops with refill gap, then a single-cycle pop of the last entry.
        issue(2'b10, 0, t);
        chk("t2_gap1", bus.op_ready, 0);
        chk("t2_old_tos", bus.tos, 16'h3333);
        chk("t2_depth2", bus.depth, 2);
        step();
        chk("t2_ready1", bus.op_ready, 1);
        chk("t2_tos2222", bus.tos, 16'h2222);
        issue(2'b10, 0, t);
        chk("t2_gap2", bus.op_ready, 0);
        step();
        chk("t2_tos1111", bus.tos, 16'h1111);
        chk("t2_depth1", bus.depth, 1);
        issue(2'b10, 0, t);
        chk("t2_nogap", bus.op_ready, 1);
        chk("t2_tos0", bus.tos, 0);
        chk("t2_empty", bus.empty, 1);

        // Underflow and err_clr priority.
        issue(2'b10, 0, t);
        issue(2'b11, 16'hBEEF, t);
        chk("t3_udf", bus.underflow, 1);
        chk("t3_depth", bus.depth, 0);
        chk("t3_tos", bus.tos, 0);
        bus.err_clr = 1; step(); bus.err_clr = 0;
        chk("t3_clr", bus.underflow, 0);
        bus.err_clr = 1; issue(2'b10, 0, t); bus.err_clr = 0;
        chk("t3_set_wins", bus.underflow, 1);
        bus.err_clr = 1; step(); bus.err_clr = 0;

        // Fill, then overflow.
        for (int i = 0; i < CAP; i++) issue(2'b01, W'(i), t);
        chk("t4_full", bus.full, 1);
        chk("t4_tos", bus.tos, CAP - 1);
        w0 = wen_cnt;
        issue(2'b01, 16'hAAAA, t);
        chk("t4_ovf", bus.overflow, 1);
        chk("t4_tos_kept", bus.tos, CAP - 1);
        chk("t4_depth", bus.depth, CAP);
        chk("t4_no_wen", wen_cnt - w0, 0);

        // Drain back-to-back.
        pop_addrs.delete();
        for (int i = 0; i < CAP; i++) begin
            issue(2'b10, 0, t);
            chk("t5_pop_val", t, CAP - 1 - i);
        end
        chk("t5_empty", bus.empty, 1);
        chk("t5_naddr", pop_addrs.size(), CAP - 1);
        for (int k = 0; k < pop_addrs.size(); k++) chk("t5_addr_seq", pop_addrs[k], CAP - 2 - k);
        bus.err_clr = 1; step(); bus.err_clr = 0;

        // Reset in the middle of a refill.
        issue(2'b01, 16'h5, t);
        issue(2'b01, 16'h6, t);
        issue(2'b10, 0, t);
        w0 = wen_cnt;
        reset = 1'b0;
        #1;
        chk("t6_depth", bus.depth, 0);
        chk("t6_tos", bus.tos, 0);
        chk("t6_ready", bus.op_ready, 0);
        step(); step();
        reset = 1'b1;
        step();
        chk("t6_no_write", wen_cnt - w0, 0);
        chk("t6_depth_after", bus.depth, 0);
        issue(2'b01, 16'h9, t);
        issue(2'b11, 16'h7, t);
        chk("t6_replace_tos", bus.tos, 16'h7);
        chk("t6_replace_depth", bus.depth, 1);

        // Randomized traffic with alternating push-heavy / pop-heavy phases.
        r = 1;
        for (int i = 0; i < 3000; i++) begin
            int p;
            if (r) begin
                bus.op_valid = ($urandom % 4) != 0;
                p = $urandom_range(0, 99);
                if (((i / 120) % 2) == 0)
                    bus.op = p < 60 ? 2'b01 : p < 80 ? 2'b10 : p < 90 ? 2'b11 : 2'b00;
                else
                    bus.op = p < 20 ? 2'b01 : p < 80 ? 2'b10 : p < 90 ? 2'b11 : 2'b00;
                bus.push_data = W'($urandom);
            end
            bus.err_clr = ($urandom % 16) == 0;
            @(negedge clk);
            r = bus.op_ready;
            step();
        end
        bus.op_valid = 0; bus.err_clr = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Controller that sequences one stack RAM (data stack or return stack) for the stack CPU.
- Caches the top-of-stack (TOS) in a register and spills/refills the remaining entries to an external synchronous single-port RAM.
- Serves push/pop/replace requests over a valid/ready handshake, with depth tracking, full/empty flags and sticky overflow/underflow errors.
- One instance per stack: cpu drives the op port; the instance owns the RAM's addr/din/wen.

Parameters:
- WIDTH, 16, stack entry width (matches STACK_WIDTH).
- DEPTH_BITS, 8, RAM address width (matches DATA_STACK_SIZE/RET_STACK_SIZE). Total capacity CAP = 2**DEPTH_BITS entries, counting the TOS; RAM addresses 0..CAP-2 are used.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- op_valid  input  1  request present.
- op_ready  output  1  request accepted on a cycle where op_valid&op_ready.
- op  input  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
- push_data  input  WIDTH  value for PUSH/REPLACE.
- tos  output  WIDTH  current top of stack; 0 when empty.
- depth  output  DEPTH_BITS+1  number of entries, 0..CAP.
- empty  output  1  depth==0.
- full  output  1  depth==CAP.
- overflow  output  1  sticky: PUSH attempted while full.
- underflow  output  1  sticky: POP/REPLACE attempted while empty.
- err_clr  input  1  synchronous clear of both sticky errors.
- mem_addr  output  DEPTH_BITS  RAM address.
- mem_din  output  WIDTH  RAM write data.
- mem_wen  output  1  RAM write enable.
- mem_dout  input  WIDTH  RAM read data, valid one cycle after address is sampled.

Behaviour:
- Reset (reset==0, async):
  - depth=0, tos=0, overflow=0, underflow=0, state=IDLE.
  - op_ready=0, mem_wen=0, mem_addr=0, mem_din=0 while reset is held.
- States: IDLE and REFILL.
- IDLE:
  - op_ready=1.
  - mem_addr, mem_din and mem_wen are combinational from op/op_valid/depth; the RAM samples them at the same edge that accepts the op.
- NOP, or op_valid=0: no change; mem_wen=0; mem_addr=0.
- PUSH:
  - depth==0: tos<=push_data, depth<=1, no RAM write.
  - 0<depth<CAP: mem_wen=1, mem_addr=depth-1, mem_din=tos; tos<=push_data; depth<=depth+1.
  - Single cycle.
- PUSH when full: no state change, mem_wen=0, overflow<=1. The op is still accepted.
- POP:
  - depth==0: no change, underflow<=1, accepted.
  - depth==1: tos<=0, depth<=0, single cycle, no RAM access.
  - depth>=2: mem_addr=depth-2, mem_wen=0; depth<=depth-1; state<=REFILL.
- REFILL:
  - op_ready=0; mem_wen=0; mem_addr is held at the refill address.
  - tos<=mem_dout; state<=IDLE.
  - A POP therefore occupies 2 cycles; the next op can be accepted in the cycle after REFILL.
- REPLACE:
  - depth>=1: tos<=push_data, depth unchanged, no RAM access, single cycle.
  - depth==0: underflow<=1, no change.
- tos, depth, empty and full are registered-state outputs. After a POP from depth>=2:
  - depth shows the new value during REFILL;
  - tos shows the old value during REFILL and the refilled value from the next cycle on.
- err_clr:
  - Clears overflow/underflow at the next edge.
  - If an error event occurs in the same cycle, set wins.
- Reset asserted during REFILL aborts the refill: all state returns to reset values, and no RAM write is ever issued.
- No wrap-around: depth saturates at CAP and 0, via the overflow/underflow rules above.
- Address arithmetic is modulo 2**DEPTH_BITS, but only the values 0..CAP-2 are ever driven.
- Handshake: op/push_data are sampled only when op_valid&op_ready. op_valid with op_ready=0 is held by the requester; nothing is sampled.

Test Plan:
- Reset, release reset (reset=1), push 0x1111, 0x2222, 0x3333 → tos=0x3333, depth=3, RAM[0]=0x1111, RAM[1]=0x2222, one mem_wen pulse per push after the first.
- Continue from 3 entries, pop twice → each pop gives op_ready=0 for exactly one cycle; tos=0x2222 then 0x1111; depth=1. A third pop gives tos=0, empty=1 with no ready gap.
- Empty stack: POP then REPLACE 0xBEEF → underflow=1, depth=0, tos=0. Pulse err_clr → underflow=0. err_clr with a simultaneous POP on empty → underflow stays 1.
- Fill with CAP pushes of values 0..CAP-1 → full=1, tos=CAP-1. One more push of 0xAAAA → overflow=1, tos unchanged, no mem_wen.
- Continue from full, pop all CAP entries back-to-back with op_valid held high → values CAP-1..0 in order, then empty=1. Mem_addr sequence is CAP-2..0.
- Push 0x5, 0x6, issue POP, assert reset during REFILL → depth=0, tos=0, op_ready=0 while in reset, no spurious write. REPLACE 0x7 on depth=1 → tos=0x7, depth unchanged.
